// File: rtl/uart_pkg.sv
// uart_pkg: state encoding and widths shared by the UART transmitter and receiver.
package uart_pkg;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;
    localparam int UART_DATA_BITS = 8;
    localparam int UART_DIV_W = 16;
endpackage

// File: rtl/uart_baud_counter.sv
// uart_baud_counter: down-counter that ticks at zero and reloads on load or tick.
module uart_baud_counter
    import uart_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [UART_DIV_W-1:0] load_val,
    output logic                  tick
);
    logic [UART_DIV_W-1:0] count;

    assign tick = count == '0;

    always_ff @(posedge clk)
        if (rst) count <= '0;
        else if (load || tick) count <= load_val;
        else count <= count - UART_DIV_W'(1);
endmodule

// File: rtl/simple_uart_transmitter.sv
// simple_uart_transmitter: 8N1/8N2 UART serialiser with a one-byte holding register
// so consecutive frames leave with no idle gap.
module simple_uart_transmitter
    import uart_pkg::*;
#(
    parameter int STOP_BITS = 1
)(
    input  logic                      clk,
    input  logic                      rst,
    input  logic [UART_DIV_W-1:0]     baud_div,
    input  logic [UART_DATA_BITS-1:0] data_in,
    input  logic                      valid,
    output logic                      ready,
    output logic                      tx,
    output logic                      busy
);
    uart_state_t state, state_nxt;
    logic [UART_DATA_BITS-1:0] hold, shifter;
    logic [UART_DIV_W-1:0] period;
    logic [2:0] bit_idx;
    logic hold_full, tick, last_data, last_stop, launch;

    assign last_data = bit_idx == 3'(UART_DATA_BITS-1);
    assign last_stop = bit_idx == 3'(STOP_BITS-1);
    // A held byte starts either from idle or straight out of the final stop bit.
    assign launch = hold_full && (state == IDLE || (state == STOP && tick && last_stop));
    assign ready = ~hold_full;
    assign busy = state != IDLE;

    uart_baud_counter u_baud (
        .clk      (clk),
        .rst      (rst),
        .load     (launch),
        .load_val (launch ? baud_div : period),
        .tick     (tick)
    );

    always_ff @(posedge clk)
        if (rst) state <= IDLE;
        else state <= state_nxt;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = hold_full ? START : IDLE;
            START:   state_nxt = tick ? DATA : START;
            DATA:    state_nxt = tick && last_data ? STOP : DATA;
            STOP:    state_nxt = !(tick && last_stop) ? STOP : hold_full ? START : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold      <= '0;
            hold_full <= 1'b0;
            shifter   <= '0;
            bit_idx   <= '0;
            period    <= '0;
            tx        <= 1'b1;
        end else begin
            if (valid && ready) begin
                hold      <= data_in;
                hold_full <= 1'b1;
            end else if (launch) hold_full <= 1'b0;
            if (launch) begin
                shifter <= hold;
                tx      <= 1'b0;
                bit_idx <= '0;
                period  <= baud_div;
            end else if (tick) begin
                case (state)
                    START: begin
                        tx      <= shifter[0];
                        bit_idx <= '0;
                    end
                    DATA: begin
                        shifter <= shifter >> 1;
                        tx      <= last_data ? 1'b1 : shifter[1];
                        bit_idx <= last_data ? 3'd0 : bit_idx + 3'd1;
                    end
                    STOP:    bit_idx <= last_stop ? 3'd0 : bit_idx + 3'd1;
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_simple_uart_transmitter.sv
// tb_simple_uart_transmitter: directed frame vectors, back-to-back, mid-frame reset
// and a loopback receiver model.
module tb_simple_uart_transmitter;
    typedef struct {
        logic        s2;
        logic [7:0]  d;
        logic [15:0] div;
        logic [10:0] frame;
    } vec_t;

    logic clk = 0, rst = 1, valid1 = 0, valid2 = 0, sel = 0, mon_en = 0;
    logic [15:0] baud_div = 0;
    logic [7:0] data_in = 0, rx_byte;
    logic ready1, tx1, busy1, ready2, tx2, busy2, tx_s, ready_s, busy_s;
    int n_cmp = 0, n_err = 0, bad = 0;
    vec_t vecs[7];
    logic [7:0] sent_q[$], rx_q[$];

    always #5 clk = ~clk;

    assign tx_s = sel ? tx2 : tx1;
    assign ready_s = sel ? ready2 : ready1;
    assign busy_s = sel ? busy2 : busy1;

    simple_uart_transmitter #(.STOP_BITS(1)) dut1 (
        .clk(clk), .rst(rst), .baud_div(baud_div), .data_in(data_in), .valid(valid1),
        .ready(ready1), .tx(tx1), .busy(busy1)
    );

    simple_uart_transmitter #(.STOP_BITS(2)) dut2 (
        .clk(clk), .rst(rst), .baud_div(baud_div), .data_in(data_in), .valid(valid2),
        .ready(ready2), .tx(tx2), .busy(busy2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic exp_b2b(input int i);
        logic [7:0] bytes[3] = '{8'h00, 8'hFF, 8'h55};
        logic [9:0] f = {1'b1, bytes[i/20], 1'b0};
        return f[(i%20)/2];
    endfunction

    task automatic run_frame(input vec_t v);
        int nb = v.s2 ? 11 : 10;
        sel = v.s2;
        baud_div = v.div;
        data_in = v.d;
        if (v.s2) valid2 = 1; else valid1 = 1;
        @(negedge clk);
        valid1 = 0;
        valid2 = 0;
        chk("accept_ready", ready_s, 0);
        chk("pre_tx", tx_s, 1);
        for (int b = 0; b < nb; b++)
            for (int c = 0; c <= int'(v.div); c++) begin
                @(negedge clk);
                chk($sformatf("tx_%02h_b%0d", v.d, b), tx_s, v.frame[b]);
                chk("busy_frame", busy_s, 1);
                if (b == 0 && c == 0) begin
                    chk("ready_at_launch", ready_s, 1);
                    baud_div = v.div + 16'd7;
                end
            end
        @(negedge clk);
        chk("busy_end", busy_s, 0);
        chk("tx_idle", tx_s, 1);
    endtask

    task automatic push(input logic [7:0] b);
        int t = 0;
        data_in = b;
        valid1 = 1;
        while (!ready1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) chk("push_timeout", ready1, 1);
        @(negedge clk);
        valid1 = 0;
    endtask

    // Receiver model: finds the start bit, samples each bit at its centre.
    initial forever begin
        @(negedge clk);
        if (mon_en && tx1 === 1'b0) begin
            repeat (9) @(negedge clk);
            rx_byte[0] = tx1;
            for (int j = 1; j < 8; j++) begin
                repeat (6) @(negedge clk);
                rx_byte[j] = tx1;
            end
            repeat (6) @(negedge clk);
            chk("lb_stop", tx1, 1);
            rx_q.push_back(rx_byte);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1'b0, 8'hA5, 16'd3, 11'b0_1_10100101_0};
        vecs[1] = '{1'b0, 8'h00, 16'd0, 11'b0_1_00000000_0};
        vecs[2] = '{1'b0, 8'hFF, 16'd0, 11'b0_1_11111111_0};
        vecs[3] = '{1'b0, 8'h3C, 16'd2, 11'b0_1_00111100_0};
        vecs[4] = '{1'b0, 8'h01, 16'd1, 11'b0_1_00000001_0};
        vecs[5] = '{1'b1, 8'h80, 16'd0, 11'b1_1_10000000_0};
        vecs[6] = '{1'b1, 8'h5A, 16'd1, 11'b1_1_01011010_0};

        rst = 1;
        valid1 = 1;
        data_in = 8'h77;
        repeat (3) begin
            @(negedge clk);
            chk("rst_tx", tx1, 1);
            chk("rst_busy", busy1, 0);
            chk("rst_ready", ready1, 1);
        end
        rst = 0;
        valid1 = 0;
        repeat (4) begin
            @(negedge clk);
            chk("idle_busy", busy1, 0);
            chk("idle_tx", tx1, 1);
            chk("idle_ready", ready1, 1);
        end

        foreach (vecs[i]) run_frame(vecs[i]);
        sel = 0;

        baud_div = 1;
        data_in = 8'h00;
        valid1 = 1;
        @(negedge clk);
        chk("b2b_ready0", ready1, 0);
        data_in = 8'hFF;
        for (int k = 1; k <= 61; k++) begin
            @(negedge clk);
            if (k <= 60) begin
                chk($sformatf("b2b_tx%0d", k), tx1, exp_b2b(k - 1));
                chk("b2b_busy", busy1, 1);
            end
            if (k == 1 || k == 21) chk("b2b_ready_launch", ready1, 1);
            if (k >= 2 && k <= 20) chk("b2b_ready_held", ready1, 0);
            if (k == 2) data_in = 8'h55;
            if (k == 22) valid1 = 0;
            if (k == 61) chk("b2b_idle", busy1, 0);
        end

        baud_div = 2;
        data_in = 8'h2C;
        valid1 = 1;
        @(negedge clk);
        data_in = 8'hC3;
        @(negedge clk);
        @(negedge clk);
        valid1 = 0;
        chk("mid_held", ready1, 0);
        repeat (15) @(negedge clk);
        chk("mid_tx_bit4", tx1, 0);
        chk("mid_busy", busy1, 1);
        rst = 1;
        @(negedge clk);
        chk("mid_rst_tx", tx1, 1);
        chk("mid_rst_busy", busy1, 0);
        chk("mid_rst_ready", ready1, 1);
        rst = 0;
        repeat (60) begin
            @(negedge clk);
            if (tx1 !== 1'b1 || busy1 !== 1'b0) bad++;
        end
        chk("no_frame_after_rst", bad, 0);

        baud_div = 5;
        mon_en = 1;
        for (int i = 0; i < 32; i++) begin
            sent_q.push_back(8'($urandom));
            push(sent_q[i]);
        end
        for (int t = 0; t < 5000 && rx_q.size() < 32; t++) @(negedge clk);
        chk("lb_count", rx_q.size(), 32);
        for (int i = 0; i < 32; i++)
            if (i < rx_q.size()) chk($sformatf("lb_byte%0d", i), rx_q[i], sent_q[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
